// File: rtl/network_interface_pkg.sv
// Shared widths, boolean constants and NI state encodings for the network interface.
package network_interface_pkg;

  localparam int unsigned NetworkAddressWidth   = 4;
  localparam int unsigned CacheBankAddressWidth = 4;
  localparam int unsigned DataWidth             = 8;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Encodings are fixed so waveforms match the rest of the codebase.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } ni_state_e;

endpackage

// File: rtl/network_interface.sv
// Core-side network interface: turns one core load/store into a router packet, keeps a single
// transaction outstanding, and returns the reply (or a timeout error) to the core.
module network_interface
  import network_interface_pkg::*;
#(
  parameter int unsigned NET_AW  = NetworkAddressWidth,
  parameter int unsigned BANK_AW = CacheBankAddressWidth,
  parameter int unsigned DW      = DataWidth,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NET_AW-1:0]         localRouterAddress,
  input  logic                      coreReqValid,
  output logic                      coreReqReady,
  input  logic                      coreWrite,
  input  logic [NET_AW+BANK_AW-1:0] coreAddress,
  input  logic [DW-1:0]             coreWriteData,
  output logic                      coreRespValid,
  output logic [DW-1:0]             coreRespData,
  output logic                      coreRespError,
  output logic [NET_AW+BANK_AW-1:0] destinationAddressOut,
  output logic [NET_AW-1:0]         requesterAddressOut,
  output logic                      readOut,
  output logic                      writeOut,
  output logic [DW-1:0]             dataOut,
  input  logic [NET_AW+BANK_AW-1:0] destinationAddressIn,
  input  logic [NET_AW-1:0]         requesterAddressIn,
  input  logic                      readIn,
  input  logic                      writeIn,
  input  logic [DW-1:0]             dataIn
);

  localparam int unsigned AW   = NET_AW + BANK_AW;
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  ni_state_e       state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   resp_data_d;
  logic            resp_error_d;
  logic            reply;
  logic            send_next;

  // Replies are routed by requester, so the inbound destination field carries no information here.
  logic unused_dest;
  assign unused_dest = ^destinationAddressIn;

  // Held low during reset so a request presented under reset is never accepted.
  assign coreReqReady = (state_q == StIdle) && reset;
  assign reply        = readIn && !writeIn && (requesterAddressIn == localRouterAddress);
  assign send_next    = (state_d == StSend);

  // Next-state, request capture, timeout counting and response selection.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_data_d  = '0;
    resp_error_d = False;
    unique case (state_q)
      StIdle: begin
        if (coreReqValid && coreReqReady) begin
          state_d = StSend;
          addr_d  = coreAddress;
          write_d = coreWrite;
          wdata_d = coreWrite ? coreWriteData : '0;
        end
      end
      StSend: begin
        cnt_d   = '0;
        state_d = write_q ? StDone : StWait;
      end
      StWait: begin
        // A reply beats a timeout landing on the same edge.
        if (reply) begin
          state_d     = StDone;
          resp_data_d = dataIn;
        end else if (cnt_q == CntLast) begin
          state_d      = StDone;
          resp_error_d = True;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, captured request and registered packet/response outputs; outputs are computed from
  // the next state so they are valid exactly while the FSM sits in SEND or DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q               <= StIdle;
      addr_q                <= '0;
      write_q               <= 1'b0;
      wdata_q               <= '0;
      cnt_q                 <= '0;
      destinationAddressOut <= '0;
      requesterAddressOut   <= '0;
      readOut               <= 1'b0;
      writeOut              <= 1'b0;
      dataOut               <= '0;
      coreRespValid         <= 1'b0;
      coreRespData          <= '0;
      coreRespError         <= 1'b0;
    end else begin
      state_q               <= state_d;
      addr_q                <= addr_d;
      write_q               <= write_d;
      wdata_q               <= wdata_d;
      cnt_q                 <= cnt_d;
      destinationAddressOut <= send_next ? addr_d : '0;
      requesterAddressOut   <= send_next ? localRouterAddress : '0;
      readOut               <= send_next && !write_d;
      writeOut              <= send_next && write_d;
      dataOut               <= send_next ? wdata_d : '0;
      coreRespValid         <= (state_d == StDone);
      coreRespData          <= resp_data_d;
      coreRespError         <= resp_error_d;
    end
  end

endmodule

// File: tb/tb_network_interface.sv
// Directed self-checking bench for network_interface; inbound router traffic is driven directly.
module tb_network_interface;

  localparam int unsigned NetAw   = 4;
  localparam int unsigned BankAw  = 4;
  localparam int unsigned Dw      = 8;
  localparam int unsigned Timeout = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NetAw-1:0]        localRouterAddress;
  logic                    coreReqValid;
  logic                    coreReqReady;
  logic                    coreWrite;
  logic [NetAw+BankAw-1:0] coreAddress;
  logic [Dw-1:0]           coreWriteData;
  logic                    coreRespValid;
  logic [Dw-1:0]           coreRespData;
  logic                    coreRespError;
  logic [NetAw+BankAw-1:0] destinationAddressOut;
  logic [NetAw-1:0]        requesterAddressOut;
  logic                    readOut;
  logic                    writeOut;
  logic [Dw-1:0]           dataOut;
  logic [NetAw+BankAw-1:0] destinationAddressIn;
  logic [NetAw-1:0]        requesterAddressIn;
  logic                    readIn;
  logic                    writeIn;
  logic [Dw-1:0]           dataIn;

  int checks = 0;
  int errors = 0;

  network_interface #(
    .NET_AW (NetAw),
    .BANK_AW(BankAw),
    .DW     (Dw),
    .TIMEOUT(Timeout)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .localRouterAddress   (localRouterAddress),
    .coreReqValid         (coreReqValid),
    .coreReqReady         (coreReqReady),
    .coreWrite            (coreWrite),
    .coreAddress          (coreAddress),
    .coreWriteData        (coreWriteData),
    .coreRespValid        (coreRespValid),
    .coreRespData         (coreRespData),
    .coreRespError        (coreRespError),
    .destinationAddressOut(destinationAddressOut),
    .requesterAddressOut  (requesterAddressOut),
    .readOut              (readOut),
    .writeOut             (writeOut),
    .dataOut              (dataOut),
    .destinationAddressIn (destinationAddressIn),
    .requesterAddressIn   (requesterAddressIn),
    .readIn               (readIn),
    .writeIn              (writeIn),
    .dataIn               (dataIn)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view of every outbound packet field; zero whenever the NI is not in SEND.
  function automatic logic [31:0] pkt();
    return {10'd0, destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut};
  endfunction

  function automatic logic [31:0] resp();
    return {22'd0, coreRespValid, coreRespError, coreRespData};
  endfunction

  task automatic clear_inbound();
    readIn             = 1'b0;
    writeIn            = 1'b0;
    requesterAddressIn = '0;
    destinationAddressIn = '0;
    dataIn             = '0;
  endtask

  task automatic request(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    coreReqValid  = 1'b1;
    coreWrite     = wr;
    coreAddress   = addr;
    coreWriteData = data;
  endtask

  initial begin
    localRouterAddress = 4'd4;
    reset = 1'b0;
    clear_inbound();
    request(1'b1, 8'h25, 8'hA5);

    // 1: reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ready", 32'(coreReqReady), 32'd0);
      check("rst_pkt", pkt(), 32'd0);
      check("rst_resp", resp(), 32'd0);
    end
    reset = 1'b0;
    coreReqValid = 1'b0;
    reset = 1'b1;
    step();
    check("idle_ready", 32'(coreReqReady), 32'd1);

    // 2: store {2,5} data A5
    request(1'b1, 8'h25, 8'hA5);
    step();
    coreReqValid = 1'b0;
    check("st_pkt", pkt(), {10'd0, 8'h25, 4'd4, 1'b0, 1'b1, 8'hA5});
    check("st_ready_busy", 32'(coreReqReady), 32'd0);
    check("st_no_resp_send", resp(), 32'd0);
    step();
    check("st_pkt_gone", pkt(), 32'd0);
    check("st_resp", resp(), {22'd0, 1'b1, 1'b0, 8'h00});
    step();
    check("st_resp_pulse", resp(), 32'd0);
    check("st_ready_back", 32'(coreReqReady), 32'd1);

    // 3: load {6,3}, reply after 5 cycles in WAIT
    request(1'b0, 8'h63, 8'hFF);
    step();
    coreReqValid = 1'b0;
    check("ld_pkt", pkt(), {10'd0, 8'h63, 4'd4, 1'b1, 1'b0, 8'h00});
    step();
    check("ld_pkt_gone", pkt(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ld_wait", resp(), 32'd0);
    end
    readIn = 1'b1;
    requesterAddressIn = 4'd4;
    dataIn = 8'h3C;
    step();
    clear_inbound();
    check("ld_resp", resp(), {22'd0, 1'b1, 1'b0, 8'h3C});
    step();
    check("ld_resp_pulse", resp(), 32'd0);

    // 4: foreign and non-reply packets ignored, timeout error TIMEOUT cycles after SEND
    request(1'b0, 8'h6A, 8'h00);
    step();
    coreReqValid = 1'b0;
    step();
    readIn = 1'b1;
    requesterAddressIn = 4'd7;
    dataIn = 8'h55;
    step();
    check("to_foreign", resp(), 32'd0);
    writeIn = 1'b1;
    requesterAddressIn = 4'd4;
    step();
    check("to_readwrite", resp(), 32'd0);
    clear_inbound();
    for (int i = 0; i < 5; i++) begin
      step();
      check("to_wait", resp(), 32'd0);
    end
    step();
    check("to_resp", resp(), {22'd0, 1'b1, 1'b1, 8'h00});
    step();
    check("to_ready_back", 32'(coreReqReady), 32'd1);

    // 5: reply on the same edge the counter reaches TIMEOUT-1
    request(1'b0, 8'h31, 8'h00);
    step();
    coreReqValid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("race_wait", resp(), 32'd0);
    end
    readIn = 1'b1;
    requesterAddressIn = 4'd4;
    dataIn = 8'h99;
    step();
    clear_inbound();
    check("race_resp", resp(), {22'd0, 1'b1, 1'b0, 8'h99});
    step();

    // 6: reset during WAIT abandons the load; late reply ignored
    request(1'b0, 8'h11, 8'h00);
    step();
    coreReqValid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("mid_rst_pkt", pkt(), 32'd0);
    check("mid_rst_resp", resp(), 32'd0);
    reset = 1'b1;
    step();
    readIn = 1'b1;
    requesterAddressIn = 4'd4;
    dataIn = 8'h77;
    step();
    clear_inbound();
    check("late_reply", resp(), 32'd0);
    check("late_ready", 32'(coreReqReady), 32'd1);
    step();
    check("late_reply_after", resp(), 32'd0);
    request(1'b1, 8'h9F, 8'h5A);
    step();
    coreReqValid = 1'b0;
    check("post_rst_pkt", pkt(), {10'd0, 8'h9F, 4'd4, 1'b0, 1'b1, 8'h5A});
    step();
    check("post_rst_resp", resp(), {22'd0, 1'b1, 1'b0, 8'h00});
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
